// File: rtl/seq_pkg.sv
// Shared types and default sizing for the instruction phase sequencer.
package seq_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_HALT = 2'd2
   } seq_state_e;

   localparam int unsigned SEQ_NUM_PHASES = 5;
   localparam int unsigned SEQ_PHASE_W    = 3;
   localparam int unsigned SEQ_CNT_W      = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous button level plus a one-cycle rising-edge pulse.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse_c
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Decoded from flops only, so the pulse never glitches on din.
   assign pulse_c = sync_q & ~prev_q;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: run/stop/halt control and retired-instruction counter.
// Optional single-step button enabled by defining SEQ_SINGLE_STEP_EN.
module phase_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned NUM_PHASES = SEQ_NUM_PHASES,
   parameter int unsigned PHASE_W    = SEQ_PHASE_W,
   parameter int unsigned CNT_W      = SEQ_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exec,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                  step,
`endif
   input  logic                  stall,
   input  logic                  stop_flag,
   output logic [PHASE_W-1:0]    phase,
   output logic [NUM_PHASES-1:0] phase_onehot,
   output logic                  running,
   output logic                  halted,
   output logic                  instr_start,
   output logic                  instr_done,
   output logic [CNT_W-1:0]      retired
);

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   seq_state_e         state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               stop_req_q, stop_req_d;
   logic               exec_pulse_c;

   sync_edge_detect u_exec_sync (
      .clk     (clk),
      .rst     (rst),
      .din     (exec),
      .pulse_c (exec_pulse_c)
   );

`ifdef SEQ_SINGLE_STEP_EN
   logic step_mode_q, step_mode_d;
   logic step_pulse_c;

   sync_edge_detect u_step_sync (
      .clk     (clk),
      .rst     (rst),
      .din     (step),
      .pulse_c (step_pulse_c)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEQ_IDLE;
         phase_q     <= '0;
         retired_q   <= '0;
         stop_req_q  <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
         step_mode_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         retired_q   <= retired_d;
         stop_req_q  <= stop_req_d;
`ifdef SEQ_SINGLE_STEP_EN
         step_mode_q <= step_mode_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      retired_d   = retired_q;
      stop_req_d  = stop_req_q;
`ifdef SEQ_SINGLE_STEP_EN
      step_mode_d = step_mode_q;
`endif
      unique case (state_q)
         SEQ_IDLE: begin
            if (exec_pulse_c) begin
               state_d = SEQ_RUN;
               phase_d = '0;
            end
`ifdef SEQ_SINGLE_STEP_EN
            else if (step_pulse_c) begin
               state_d     = SEQ_RUN;
               phase_d     = '0;
               step_mode_d = 1'b1;
            end
`endif
         end
         SEQ_RUN: begin
            // A stalled cycle leaves every register untouched, including stop_req.
            if (!stall) begin
               if (exec_pulse_c) begin
                  stop_req_d = 1'b1;
               end
               if (phase_q == LAST_PHASE) begin
                  phase_d = '0;
                  if (retired_q != CNT_MAX) begin
                     retired_d = retired_q + CNT_W'(1);
                  end
                  // HLT outranks any pending stop or single-step return.
                  if (stop_flag) begin
                     state_d    = SEQ_HALT;
                     stop_req_d = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                     step_mode_d = 1'b0;
`endif
                  end
`ifdef SEQ_SINGLE_STEP_EN
                  else if (step_mode_q) begin
                     state_d     = SEQ_IDLE;
                     stop_req_d  = 1'b0;
                     step_mode_d = 1'b0;
                  end
`endif
                  else if (stop_req_q) begin
                     state_d    = SEQ_IDLE;
                     stop_req_d = 1'b0;
                  end
               end else begin
                  phase_d = phase_q + PHASE_W'(1);
               end
            end
         end
         SEQ_HALT: begin
            phase_d = '0;
         end
         default: begin
            state_d = SEQ_IDLE;
            phase_d = '0;
         end
      endcase
   end

   // Status decode; stall is the only input reaching an output.
   assign phase        = phase_q;
   assign retired      = retired_q;
   assign running      = (state_q == SEQ_RUN);
   assign halted       = (state_q == SEQ_HALT);
   assign instr_start  = running && (phase_q == '0);
   assign instr_done   = running && (phase_q == LAST_PHASE) && !stall;
   assign phase_onehot = running ? (NUM_PHASES'(1) << phase_q) : '0;

endmodule
